// File: rtl/gat_pkg.sv
// Shared types and derived widths for the GAT parameter loader.
// Optional checksum logic is selected elsewhere by PARAM_LOADER_CHECKSUM_EN.
package gat_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_HEADS  = 2;
  localparam int DEF_W_ROWS     = 4;
  localparam int DEF_W_COLS     = 4;
  localparam int DEF_A_DEPTH    = 8;
  localparam int DEF_RD_LAT     = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  // Address width that never collapses to zero bits for tiny memories.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int WGT_SRC_ADDR_W = clog2_min1(DEF_NUM_HEADS * DEF_W_ROWS * DEF_W_COLS);
  localparam int BANK_ADDR_W    = clog2_min1(DEF_NUM_HEADS * DEF_W_ROWS);
  localparam int A_SRC_ADDR_W   = clog2_min1(DEF_NUM_HEADS * DEF_A_DEPTH);

endpackage

// File: rtl/gat_src_streamer.sv
// Generic source-BRAM streamer: edge-started FSM, read address counter, RD_LAT index pipeline.
// With PARAM_LOADER_CHECKSUM_EN defined it also sums every word written in the current load.
module gat_src_streamer
  import gat_pkg::*;
#(
  parameter int N          = 32,
  parameter int RD_LAT     = 1,
  parameter int DATA_WIDTH = 16,
  localparam int AW        = clog2_min1(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld,
  input  logic                  reload,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  enb,
  output logic [AW-1:0]         addr,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_idx,
  output logic                  rdy,
  output logic [DATA_WIDTH-1:0] csum,
  output loader_state_e         state
);

  logic              vld_q;
  logic              vld_qq;
  logic              start;
  logic [1:0]        drain_cnt;
  logic [RD_LAT-1:0] v_pipe;
  logic [AW-1:0]     k_pipe [RD_LAT];

  // A load starts only on a fresh 0->1 transition of vld seen while idle.
  assign start = vld_q & ~vld_qq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      enb       <= 1'b0;
      addr      <= '0;
      rdy       <= 1'b0;
      drain_cnt <= '0;
      vld_q     <= 1'b0;
      vld_qq    <= 1'b0;
    end else begin
      vld_q  <= vld;
      vld_qq <= vld_q;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            enb   <= 1'b1;
            addr  <= '0;
          end
        end
        FETCH: begin
          if (addr == AW'(N - 1)) begin
            state     <= DRAIN;
            enb       <= 1'b0;
            addr      <= '0;
            drain_cnt <= '0;
          end else begin
            addr <= addr + AW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(RD_LAT - 1)) begin
            state <= DONE;
            rdy   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          if (reload) begin
            state <= IDLE;
            rdy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Index pipeline tracks which source word is on din RD_LAT cycles after issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_pipe <= '0;
    end else begin
      v_pipe[0] <= enb;
      for (int i = 1; i < RD_LAT; i++) v_pipe[i] <= v_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    k_pipe[0] <= addr;
    for (int i = 1; i < RD_LAT; i++) k_pipe[i] <= k_pipe[i-1];
  end

  assign wr_en  = v_pipe[RD_LAT-1];
  assign wr_idx = k_pipe[RD_LAT-1];

`ifdef PARAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (wr_en) begin
      csum <= csum + din;
    end
  end
`else
  logic unused_din;
  assign unused_din = ^din;
  assign csum       = '0;
`endif

endmodule

// File: rtl/gat_param_loader.sv
// Multi-head parameter loader: weight banks per column plus a flat attention register file.
// Checksum outputs are live only when PARAM_LOADER_CHECKSUM_EN is defined.
module gat_param_loader
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_HEADS  = DEF_NUM_HEADS,
  parameter int W_ROWS     = DEF_W_ROWS,
  parameter int W_COLS     = DEF_W_COLS,
  parameter int A_DEPTH    = DEF_A_DEPTH,
  parameter int RD_LAT     = DEF_RD_LAT,
  localparam int NW         = NUM_HEADS * W_ROWS * W_COLS,
  localparam int NA         = NUM_HEADS * A_DEPTH,
  localparam int BANK_DEPTH = NUM_HEADS * W_ROWS,
  localparam int WGT_AW     = clog2_min1(NW),
  localparam int BANK_AW    = clog2_min1(BANK_DEPTH),
  localparam int A_AW       = clog2_min1(NA),
  localparam int COL_W      = clog2_min1(W_COLS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wgt_vld_i,
  input  logic [DATA_WIDTH-1:0]          wgt_bram_dout,
  output logic                           wgt_bram_enb,
  output logic [WGT_AW-1:0]              wgt_bram_addrb,
  input  logic [W_COLS*BANK_AW-1:0]      mult_wgt_addrb,
  output logic [W_COLS*DATA_WIDTH-1:0]   mult_wgt_dout,
  output logic                           w_rdy_o,
  input  logic                           a_vld_i,
  input  logic [DATA_WIDTH-1:0]          a_bram_dout,
  output logic                           a_bram_enb,
  output logic [A_AW-1:0]                a_bram_addrb,
  output logic [NA*DATA_WIDTH-1:0]       a_flat_o,
  output logic                           a_rdy_o,
  input  logic                           reload_i,
  output logic [DATA_WIDTH-1:0]          w_csum_o,
  output logic [DATA_WIDTH-1:0]          a_csum_o
);

  logic                  w_wr;
  logic [WGT_AW-1:0]     w_idx;
  logic [COL_W-1:0]      w_col;
  logic [BANK_AW-1:0]    w_row;
  logic                  a_wr;
  logic [A_AW-1:0]       a_idx;
  loader_state_e         w_state;
  loader_state_e         a_state;
  logic [3:0]            dbg_state_unused;

  // Both FSM states gathered in one place for probing.
  assign dbg_state_unused = {w_state, a_state};

  gat_src_streamer #(
    .N          (NW),
    .RD_LAT     (RD_LAT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wgt (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld    (wgt_vld_i),
    .reload (reload_i),
    .din    (wgt_bram_dout),
    .enb    (wgt_bram_enb),
    .addr   (wgt_bram_addrb),
    .wr_en  (w_wr),
    .wr_idx (w_idx),
    .rdy    (w_rdy_o),
    .csum   (w_csum_o),
    .state  (w_state)
  );

  gat_src_streamer #(
    .N          (NA),
    .RD_LAT     (RD_LAT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_att (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld    (a_vld_i),
    .reload (reload_i),
    .din    (a_bram_dout),
    .enb    (a_bram_enb),
    .addr   (a_bram_addrb),
    .wr_en  (a_wr),
    .wr_idx (a_idx),
    .rdy    (a_rdy_o),
    .csum   (a_csum_o),
    .state  (a_state)
  );

  // Source is head-major then row-major, so word k lands in column k%W_COLS, row k/W_COLS.
  assign w_col = COL_W'(w_idx % WGT_AW'(W_COLS));
  assign w_row = BANK_AW'(w_idx / WGT_AW'(W_COLS));

  for (genvar c = 0; c < W_COLS; c++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (rst_n && w_wr && (w_col == COL_W'(c))) mem[w_row] <= wgt_bram_dout;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= mem[mult_wgt_addrb[c*BANK_AW +: BANK_AW]];
    end

    assign mult_wgt_dout[c*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_flat_o <= '0;
    end else if (a_wr) begin
      a_flat_o[a_idx*DATA_WIDTH +: DATA_WIDTH] <= a_bram_dout;
    end
  end

endmodule

// File: tb/tb_gat_param_loader.sv
// Bench for gat_param_loader: two instances (RD_LAT 1 and 3) share stimulus; each has its own source BRAM model.
// Checksum expectations follow PARAM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_gat_param_loader;

  localparam int DW  = 16;
  localparam int WC  = 4;
  localparam int AD  = 8;
  localparam int NW  = 32;
  localparam int NA  = 16;
  localparam int BD  = 8;
  localparam int WAW = 5;
  localparam int BAW = 3;
  localparam int AAW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             wgt_vld;
  logic             a_vld;
  logic             reload;
  logic [WC*BAW-1:0] mult_addr;

  logic [DW-1:0] wgt_mem [NW];
  logic [DW-1:0] a_mem   [NA];

  logic [DW-1:0]    w_dout1, a_dout1, w_dout3, a_dout3;
  logic             w_enb1, a_enb1, w_enb3, a_enb3;
  logic [WAW-1:0]   w_addr1, w_addr3;
  logic [AAW-1:0]   a_addr1, a_addr3;
  logic [WC*DW-1:0] mult_dout1, mult_dout3;
  logic             w_rdy1, a_rdy1, w_rdy3, a_rdy3;
  logic [NA*DW-1:0] a_flat1, a_flat3;
  logic [DW-1:0]    w_csum1, a_csum1, w_csum3, a_csum3;

  gat_param_loader #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wgt_vld_i(wgt_vld), .wgt_bram_dout(w_dout1), .wgt_bram_enb(w_enb1), .wgt_bram_addrb(w_addr1),
    .mult_wgt_addrb(mult_addr), .mult_wgt_dout(mult_dout1), .w_rdy_o(w_rdy1),
    .a_vld_i(a_vld), .a_bram_dout(a_dout1), .a_bram_enb(a_enb1), .a_bram_addrb(a_addr1),
    .a_flat_o(a_flat1), .a_rdy_o(a_rdy1), .reload_i(reload),
    .w_csum_o(w_csum1), .a_csum_o(a_csum1)
  );

  gat_param_loader #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .wgt_vld_i(wgt_vld), .wgt_bram_dout(w_dout3), .wgt_bram_enb(w_enb3), .wgt_bram_addrb(w_addr3),
    .mult_wgt_addrb(mult_addr), .mult_wgt_dout(mult_dout3), .w_rdy_o(w_rdy3),
    .a_vld_i(a_vld), .a_bram_dout(a_dout3), .a_bram_enb(a_enb3), .a_bram_addrb(a_addr3),
    .a_flat_o(a_flat3), .a_rdy_o(a_rdy3), .reload_i(reload),
    .w_csum_o(w_csum3), .a_csum_o(a_csum3)
  );

  // Source BRAM models: address registered, data visible after the stated latency.
  logic [WAW-1:0] wq1;
  logic [AAW-1:0] aq1;
  logic [WAW-1:0] wq3 [3];
  logic [AAW-1:0] aq3 [3];

  always @(posedge clk) begin
    wq1    <= w_addr1;
    aq1    <= a_addr1;
    wq3[0] <= w_addr3;
    wq3[1] <= wq3[0];
    wq3[2] <= wq3[1];
    aq3[0] <= a_addr3;
    aq3[1] <= aq3[0];
    aq3[2] <= aq3[1];
  end

  assign w_dout1 = wgt_mem[wq1];
  assign a_dout1 = a_mem[aq1];
  assign w_dout3 = wgt_mem[wq3[2]];
  assign a_dout3 = a_mem[aq3[2]];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_w_rdy1"}, w_rdy1, 0);
    check({tag, "_a_rdy1"}, a_rdy1, 0);
    check({tag, "_w_rdy3"}, w_rdy3, 0);
    check({tag, "_a_rdy3"}, a_rdy3, 0);
    check({tag, "_enb1"}, {w_enb1, a_enb1}, 0);
    check({tag, "_enb3"}, {w_enb3, a_enb3}, 0);
    check({tag, "_addr1"}, {w_addr1, a_addr1}, 0);
    check({tag, "_addr3"}, {w_addr3, a_addr3}, 0);
    check({tag, "_aflat1"}, |a_flat1, 0);
    check({tag, "_aflat3"}, |a_flat3, 0);
    check({tag, "_mult1"}, |mult_dout1, 0);
    check({tag, "_mult3"}, |mult_dout3, 0);
    check({tag, "_csum1"}, {w_csum1, a_csum1}, 0);
    check({tag, "_csum3"}, {w_csum3, a_csum3}, 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < NW; k++) wgt_mem[k] = DW'($urandom);
    for (int k = 0; k < NA; k++) a_mem[k]   = DW'($urandom);
  endtask

  // Reference view: bank c row r holds source word r*WC+c; slice k holds attention word k.
  task automatic check_contents(input string tag);
    int row;
    int wsum;
    int asum;
    logic [DW-1:0] want;
    for (int r = 0; r < BD; r++) begin
      @(negedge clk);
      for (int c = 0; c < WC; c++) mult_addr[c*BAW +: BAW] = BAW'((r + c) % BD);
      @(posedge clk);
      #1;
      for (int c = 0; c < WC; c++) begin
        row  = (r + c) % BD;
        want = wgt_mem[row*WC + c];
        check($sformatf("%s_bank%0d_row%0d_lat1", tag, c, row), mult_dout1[c*DW +: DW], want);
        check($sformatf("%s_bank%0d_row%0d_lat3", tag, c, row), mult_dout3[c*DW +: DW], want);
      end
    end
    for (int k = 0; k < NA; k++) begin
      check($sformatf("%s_aflat%0d_lat1", tag, k), a_flat1[k*DW +: DW], a_mem[k]);
      check($sformatf("%s_aflat%0d_lat3", tag, k), a_flat3[k*DW +: DW], a_mem[k]);
    end
    wsum = 0;
    asum = 0;
    for (int k = 0; k < NW; k++) wsum += int'(wgt_mem[k]);
    for (int k = 0; k < NA; k++) asum += int'(a_mem[k]);
`ifdef PARAM_LOADER_CHECKSUM_EN
    check({tag, "_w_csum1"}, w_csum1, DW'(wsum));
    check({tag, "_a_csum1"}, a_csum1, DW'(asum));
    check({tag, "_w_csum3"}, w_csum3, DW'(wsum));
    check({tag, "_a_csum3"}, a_csum3, DW'(asum));
`else
    check({tag, "_w_csum1"}, w_csum1, 0);
    check({tag, "_a_csum1"}, a_csum1, 0);
    check({tag, "_w_csum3"}, w_csum3, 0);
    check({tag, "_a_csum3"}, a_csum3, 0);
`endif
  endtask

  // Starts a load (attention start delayed by a_off edges), optionally pulses reload or
  // glitches the weight vld mid-load, and measures rdy latency from the sampling edge.
  task automatic run_load(input string tag, input int a_off, input int reload_at, input bit glitch);
    int lw1, la1, lw3, la3;
    int wm1, am1, wm3, am3;
    lw1 = -1; la1 = -1; lw3 = -1; la3 = -1;
    wm1 = -1; am1 = -1; wm3 = -1; am3 = -1;
    @(negedge clk);
    wgt_vld = 1'b1;
    if (a_off == 0) a_vld = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk);
      #1;
      if (w_rdy1 && lw1 < 0) lw1 = i;
      if (a_rdy1 && la1 < 0) la1 = i;
      if (w_rdy3 && lw3 < 0) lw3 = i;
      if (a_rdy3 && la3 < 0) la3 = i;
      if (w_enb1 && int'(w_addr1) > wm1) wm1 = int'(w_addr1);
      if (a_enb1 && int'(a_addr1) > am1) am1 = int'(a_addr1);
      if (w_enb3 && int'(w_addr3) > wm3) wm3 = int'(w_addr3);
      if (a_enb3 && int'(a_addr3) > am3) am3 = int'(a_addr3);
      reload = (i + 1 == reload_at);
      if (a_off > 0 && i + 1 == a_off) a_vld = 1'b1;
      if (glitch) wgt_vld = (i + 1 != 4);
    end
    check({tag, "_w_lat1"}, lw1, NW + 1 + 1);
    check({tag, "_a_lat1"}, la1, a_off + NA + 1 + 1);
    check({tag, "_w_lat3"}, lw3, NW + 3 + 1);
    check({tag, "_a_lat3"}, la3, a_off + NA + 3 + 1);
    check({tag, "_rdy_held"}, {w_rdy1, a_rdy1, w_rdy3, a_rdy3}, 4'hf);
    check({tag, "_w_maxaddr1"}, wm1, NW - 1);
    check({tag, "_a_maxaddr1"}, am1, NA - 1);
    check({tag, "_w_maxaddr3"}, wm3, NW - 1);
    check({tag, "_a_maxaddr3"}, am3, NA - 1);
    check({tag, "_addr_wrap"}, {w_addr1, a_addr1, w_addr3, a_addr3}, 0);
    check_contents(tag);
  endtask

  int bad;

  initial begin
    rst_n     = 1'b0;
    wgt_vld   = 1'b0;
    a_vld     = 1'b0;
    reload    = 1'b0;
    mult_addr = '0;
    for (int k = 0; k < NW; k++) wgt_mem[k] = DW'(k + 1);
    for (int k = 0; k < NA; k++) a_mem[k]   = DW'(100 + k);

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed load; a vld glitch and a reload pulse during FETCH must both be ignored.
    run_load("directed", 0, 6, 1'b1);
    @(negedge clk);
    mult_addr[2*BAW +: BAW] = BAW'(5);
    @(posedge clk);
    #1;
    check("directed_bank2_addr5", mult_dout1[2*DW +: DW], 23);
    check("directed_head1_word3", a_flat1[(1*AD + 3)*DW +: DW], 111);
`ifdef PARAM_LOADER_CHECKSUM_EN
    check("directed_w_csum_total", w_csum1, 528);
`else
    check("directed_w_csum_total", w_csum1, 0);
`endif

    // Reload with vld held high: flags drop and no new load begins.
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_rdy_drop", {w_rdy1, a_rdy1, w_rdy3, a_rdy3}, 0);
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (w_rdy1 | a_rdy1 | w_rdy3 | a_rdy3 | w_enb1 | a_enb1 | w_enb3 | a_enb3) bad++;
    end
    check("held_vld_no_restart", bad, 0);

    // Fresh edge with random data; attention starts late so a reload lands on the final weight DRAIN.
    @(negedge clk);
    wgt_vld = 1'b0;
    a_vld   = 1'b0;
    repeat (3) @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    fill_random();
    run_load("random_drain_reload", int'($urandom_range(17, 20)), NW + 1 + 1, 1'b0);

    // Reset mid-load aborts cleanly; a new edge then performs a full load.
    @(negedge clk);
    reload  = 1'b1;
    wgt_vld = 1'b0;
    a_vld   = 1'b0;
    @(negedge clk);
    reload = 1'b0;
    repeat (2) @(negedge clk);
    fill_random();
    wgt_vld = 1'b1;
    a_vld   = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    rst_n   = 1'b1;
    wgt_vld = 1'b0;
    a_vld   = 1'b0;
    repeat (3) @(negedge clk);
    fill_random();
    run_load("after_abort", int'($urandom_range(0, 5)), 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
